count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
Upstream control stage for the 4-bit counter. Converts a raw, bouncing, asynchronous push-button into a clean run/stop level (COUNTON) that drives the counter's COUNTON input directly. Each debounced press toggles COUNTON; a synchronous STOP input forces it off. A one-cycle PRESS_PULSE is also produced for monitoring.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive synchronized samples needed to accept a press or release; legal range 2..255
CNT_W, 8, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RST_X  input  1  asynchronous active-low reset
BTN_IN  input  1  raw button, active-high, asynchronous to CLK, may bounce
STOP  input  1  synchronous, active-high; forces COUNTON to 0
COUNTON  output  1  registered run enable to the counter
PRESS_PULSE  output  1  registered one-cycle strobe on each accepted press

Behaviour:
- Reset (RST_X=0, asynchronous): sync flops=0, state=IDLE, debounce count=0, COUNTON=0, PRESS_PULSE=0. The block leaves reset on the first rising CLK after RST_X rises.
- Synchronizer: two flops, BTN_IN->s1->s2. Only s2 is used downstream.
- FSM states: IDLE (released, stable), PRESS_WAIT, PRESSED (held, stable), RELEASE_WAIT.
- IDLE: s2=1 -> PRESS_WAIT, cnt=1; otherwise stay, cnt=0.
- PRESS_WAIT: s2=0 -> IDLE, cnt=0 (bounce rejected). s2=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, toggle COUNTON, PRESS_PULSE=1 for exactly one cycle.
- PRESSED: s2=0 -> RELEASE_WAIT, cnt=1; otherwise stay.
- RELEASE_WAIT: s2=1 -> PRESSED, cnt=0. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0. Otherwise cnt+1. A release never toggles COUNTON and never pulses.
- Latency: if BTN_IN is first sampled high at edge k and stays high, COUNTON toggles and PRESS_PULSE rises at edge k+1+DEBOUNCE_CYCLES. PRESS_PULSE is low again after edge k+2+DEBOUNCE_CYCLES.
- STOP=1 sets COUNTON to 0 at the next edge. STOP has priority over a toggle in the same cycle. PRESS_PULSE still fires in that case. The FSM is unaffected by STOP.
- Holding the button generates one press only. The next press requires a full debounced release first.
- The counter never wraps: it saturates by construction, because the FSM leaves the WAIT state at DEBOUNCE_CYCLES-1.
- Reset asserted mid-debounce discards the partial count and forces COUNTON=0 immediately (asynchronously).
- No combinational path exists from any input to any output.

Decomposition:
- Shared package/header (count_ctrl_defs): 2-bit state encodings ST_IDLE=0, ST_PRESS_WAIT=1, ST_PRESSED=2, ST_RELEASE_WAIT=3.
- Sub-module sync_2ff (ports CLK, RST_X, D, Q; reset value 0). It is reused for any other asynchronous input in the design.
- The FSM, counter and output registers stay in count_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and a 10 ns clock.
1. Reset: hold RST_X=0 with BTN_IN=1 for 3 cycles -> COUNTON=0 and PRESS_PULSE=0 throughout; no toggle during reset.
2. Clean press: BTN_IN 0->1 sampled at edge k and held 20 cycles -> COUNTON 0->1 and PRESS_PULSE=1 at edge k+5 only; no further change while held.
3. Bounce rejection: BTN_IN pattern 1,1,0,1,1,0 (one value per cycle), then 0 -> COUNTON stays 0 and PRESS_PULSE never asserts.
4. Toggle off: complete press, release held ≥8 cycles, then press again -> COUNTON goes 1 and then back to 0, with exactly two PRESS_PULSE strobes. Connect the block to the counter: CNT4 increments only while COUNTON=1.
5. STOP priority: STOP=1 in the same cycle that a press completes while COUNTON=0 -> COUNTON stays 0 and PRESS_PULSE=1. With COUNTON=1, a single STOP cycle -> COUNTON=0 at the next edge.
6. Reset mid-debounce: press held 2 cycles, pulse RST_X low for 1 cycle, keep holding -> COUNTON=0 immediately on RST_X fall; the press is recognized 5 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/count_ctrl_defs.sv
// Shared state encodings for the push-button run/stop control stage.
package count_ctrl_defs;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE         = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PRESSED      = 2'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic CLK,
  input  logic RST_X,
  input  logic D,
  output logic Q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = D;
    s2_d = s1_q;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign Q = s2_q;

endmodule

// File: rtl/count_ctrl.sv
// Debounces a raw push-button into a toggling run enable (COUNTON) with a
// synchronous STOP override and a one-cycle press strobe.
module count_ctrl
  import count_ctrl_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic BTN_IN,
  input  logic STOP,
  output logic COUNTON,
  output logic PRESS_PULSE
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               btn_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               counton_q, counton_d;
  logic               press_pulse_q, press_pulse_d;
  logic               toggle;

  sync_2ff u_btn_sync (
    .CLK   (CLK),
    .RST_X (RST_X),
    .D     (BTN_IN),
    .Q     (btn_s)
  );

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES equal samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          toggle  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // STOP wins over a same-cycle toggle; the strobe still reports the press.
  always_comb begin
    press_pulse_d = toggle;
    counton_d     = STOP ? 1'b0 : (counton_q ^ toggle);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      counton_q     <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      counton_q     <= counton_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  assign COUNTON     = counton_q;
  assign PRESS_PULSE = press_pulse_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl against a run-length debounce model.
module tb_count_ctrl;

  localparam int DB = 4;

  logic clk;
  logic rst_x;
  logic btn;
  logic stop;
  logic counton;
  logic pulse;

  count_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .CLK         (clk),
    .RST_X       (rst_x),
    .BTN_IN      (btn),
    .STOP        (stop),
    .COUNTON     (counton),
    .PRESS_PULSE (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit counter enabled by COUNTON.
  logic [3:0] cnt4;
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x) cnt4 <= 4'd0;
    else if (counton) cnt4 <= cnt4 + 4'd1;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Model: samples reach the debouncer two edges late; the accepted level
  // flips once DB consecutive samples disagree with it; a flip to 1 is a press.
  bit         pipe[$];
  bit         acc;
  int         run;
  bit         exp_con;
  bit         exp_pul;
  logic [3:0] exp_cnt4;

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(1'b0);
    pipe.push_back(1'b0);
    acc      = 1'b0;
    run      = 0;
    exp_con  = 1'b0;
    exp_pul  = 1'b0;
    exp_cnt4 = 4'd0;
  endtask

  task automatic step(input bit b, input bit s);
    bit seen;
    bit press;
    @(negedge clk);
    btn  = b;
    stop = s;
    @(posedge clk);
    seen = pipe.pop_front();
    pipe.push_back(b);
    press = 1'b0;
    if (exp_con) exp_cnt4 = exp_cnt4 + 4'd1;
    if (seen != acc) begin
      run++;
      if (run == DB) begin
        acc   = seen;
        run   = 0;
        press = seen;
      end
    end else begin
      run = 0;
    end
    exp_pul = press;
    exp_con = s ? 1'b0 : (exp_con ^ press);
    #1;
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    btn   = 1'b1;
    stop  = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (counton !== 1'b0) begin n_err++; $display("FAIL reset_counton cyc%0d got %b want 0", i, counton); end
      n_cmp++;
      if (pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse cyc%0d got %b want 0", i, pulse); end
    end
    #2;
    btn   = 1'b0;
    rst_x = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    n_cmp++;
    if (counton !== 1'b0) begin n_err++; $display("FAIL post_reset_counton got %b want 0", counton); end
  endtask

  task automatic test_clean_press();
    int npulse = 0;
    int pidx   = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (pulse === 1'b1) begin npulse++; pidx = i; end
      n_cmp++;
      if (counton !== exp_con) begin n_err++; $display("FAIL press_counton cyc%0d got %b want %b", i, counton, exp_con); end
      n_cmp++;
      if (pulse !== exp_pul) begin n_err++; $display("FAIL press_pulse cyc%0d got %b want %b", i, pulse, exp_pul); end
    end
    n_cmp++;
    if (npulse != 1) begin n_err++; $display("FAIL press_pulse_count got %0d want 1", npulse); end
    n_cmp++;
    if (pidx != DB + 1) begin n_err++; $display("FAIL press_latency got %0d want %0d", pidx, DB + 1); end
    n_cmp++;
    if (counton !== 1'b1) begin n_err++; $display("FAIL press_final got %b want 1", counton); end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit start;
    int npulse = 0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    start = counton;
    for (int i = 0; i < 14; i++) begin
      step(i < 6 ? pat[i] : 1'b0, 1'b0);
      if (pulse === 1'b1) npulse++;
      n_cmp++;
      if (counton !== exp_con) begin n_err++; $display("FAIL bounce_counton cyc%0d got %b want %b", i, counton, exp_con); end
    end
    n_cmp++;
    if (npulse != 0) begin n_err++; $display("FAIL bounce_pulses got %0d want 0", npulse); end
    n_cmp++;
    if (counton !== 1'b0) begin n_err++; $display("FAIL bounce_counton_final got %b want 0 (start %b)", counton, start); end
  endtask

  task automatic test_toggle_off();
    int npulse = 0;
    bit saw_on = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 10; i++) begin
        step(ph % 2 == 0, 1'b0);
        if (pulse === 1'b1) npulse++;
        if (counton === 1'b1) saw_on = 1'b1;
        n_cmp++;
        if (counton !== exp_con) begin n_err++; $display("FAIL toggle_counton ph%0d cyc%0d got %b want %b", ph, i, counton, exp_con); end
        n_cmp++;
        if (cnt4 !== exp_cnt4) begin n_err++; $display("FAIL toggle_cnt4 ph%0d cyc%0d got %0d want %0d", ph, i, cnt4, exp_cnt4); end
      end
    end
    n_cmp++;
    if (npulse != 2) begin n_err++; $display("FAIL toggle_pulses got %0d want 2", npulse); end
    n_cmp++;
    if (!saw_on || counton !== 1'b0) begin n_err++; $display("FAIL toggle_sequence saw_on %b final %b want 1/0", saw_on, counton); end
  endtask

  task automatic test_stop();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i == DB + 1);
      if (i == DB + 1) begin
        n_cmp++;
        if (counton !== 1'b0) begin n_err++; $display("FAIL stop_prio_counton got %b want 0", counton); end
        n_cmp++;
        if (pulse !== 1'b1) begin n_err++; $display("FAIL stop_prio_pulse got %b want 1", pulse); end
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (counton !== 1'b1) begin n_err++; $display("FAIL stop_setup got %b want 1", counton); end
    step(1'b1, 1'b1);
    n_cmp++;
    if (counton !== 1'b0) begin n_err++; $display("FAIL stop_clear got %b want 0", counton); end
    step(1'b1, 1'b0);
    n_cmp++;
    if (counton !== 1'b0) begin n_err++; $display("FAIL stop_held_no_toggle got %b want 0", counton); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int pidx = -1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    n_cmp++;
    if (counton !== 1'b1) begin n_err++; $display("FAIL midrst_setup got %b want 1", counton); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst_x = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (counton !== 1'b0) begin n_err++; $display("FAIL midrst_async_counton got %b want 0", counton); end
    @(posedge clk);
    #2;
    rst_x = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (pulse === 1'b1 && pidx < 0) pidx = i;
      n_cmp++;
      if (counton !== exp_con) begin n_err++; $display("FAIL midrst_counton cyc%0d got %b want %b", i, counton, exp_con); end
    end
    n_cmp++;
    if (pidx != DB + 1) begin n_err++; $display("FAIL midrst_latency got %0d want %0d", pidx, DB + 1); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit b = 1'b0;
    int hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        b    = bit'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      step(b, $urandom_range(0, 15) == 0);
      n_cmp++;
      if (counton !== exp_con) begin n_err++; $display("FAIL rand_counton cyc%0d got %b want %b", i, counton, exp_con); end
      n_cmp++;
      if (pulse !== exp_pul) begin n_err++; $display("FAIL rand_pulse cyc%0d got %b want %b", i, pulse, exp_pul); end
      n_cmp++;
      if (cnt4 !== exp_cnt4) begin n_err++; $display("FAIL rand_cnt4 cyc%0d got %0d want %0d", i, cnt4, exp_cnt4); end
    end
  endtask

  initial begin
    rst_x = 1'b0;
    btn   = 1'b0;
    stop  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_toggle_off();
    test_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
